// File: rtl/gost_pkg.sv
// Shared definitions for the Magma (GOST R 34.12-2015, 64-bit block) cipher sequencer.
package gost_pkg;

    localparam int MAGMA_ROUNDS = 32;
    localparam int BLOCK_W      = 64;
    localparam int KEY_W        = 256;
    localparam int WORD_W       = 32;
    localparam int ROL_AMT      = 11;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Substitution tables pi0..pi7; row j serves nibble j (row 0 = least significant nibble).
    // Within a row, entry v sits at bits [4v+3:4v].
    localparam logic [7:0][63:0] SBOX_TAB = {
        64'h2bc96af43850de71,   // pi7
        64'h73ad0b4fc19652e8,   // pi6
        64'h0e34187bac296fd5,   // pi5
        64'hc24be390d618a5f7,   // pi4
        64'hb9e35a076f4d128c,   // pi3
        64'h069c471edaf2853b,   // pi2
        64'hf0db74e1c5a93286,   // pi1
        64'h1f307d8e9b5a264c    // pi0
    };

    // Nibble-wise substitution of a 32-bit word.
    function automatic word_t s_box(input word_t x);
        word_t y;
        y = '0;
        for (int j = 0; j < 8; j++) begin
            y[4*j +: 4] = SBOX_TAB[j][{x[4*j +: 4], 2'b00} +: 4];
        end
        return y;
    endfunction

    // Zero-based key word (0 = K1 ... 7 = K8) used by round 'round'.
    // Encrypt walks K1..K8 three times then K8..K1; decrypt walks K1..K8 once then K8..K1 three times.
    // Every descending pass is just the inverted low three bits of the round number.
    function automatic logic [2:0] key_index(input logic [4:0] round, input logic decrypt);
        logic ascending;
        ascending = decrypt ? (round < 5'd8) : (round < 5'd24);
        return ascending ? round[2:0] : ~round[2:0];
    endfunction

endpackage

// File: rtl/gost_round.sv
// One Feistel round of Magma: (a1, a0) -> (a0, g(a0) ^ a1), g(x) = rol11(s_box(x + k)).
// Always swaps; the final no-swap round is undone by the controller.
module gost_round
    import gost_pkg::*;
(
    input  logic [WORD_W-1:0] a1_i,
    input  logic [WORD_W-1:0] a0_i,
    input  logic [WORD_W-1:0] rkey_i,
    output logic [WORD_W-1:0] a1_o,
    output logic [WORD_W-1:0] a0_o
);

    word_t sum;
    word_t sub;

    // Key add (carry-out dropped), substitute, rotate left by 11, mix into the other half.
    always_comb begin
        sum  = a0_i + rkey_i;
        sub  = s_box(sum);
        a1_o = a0_i;
        a0_o = {sub[WORD_W-ROL_AMT-1:0], sub[WORD_W-1:WORD_W-ROL_AMT]} ^ a1_i;
    end

endmodule

// File: rtl/gost_round_ctrl.sv
// Magma block sequencer: latches block and key on start, runs 32 rounds UNROLL at a time,
// returns the result with a one-cycle done pulse. One block in flight at a time.
module gost_round_ctrl
    import gost_pkg::*;
#(
    parameter int UNROLL = 1    // rounds per clock: 1, 2, 4 or 8
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               decrypt,
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] din,
    output logic               ready,
    output logic               done,
    output logic [BLOCK_W-1:0] dout
);

    localparam logic [4:0] CNT_STEP = 5'(UNROLL);
    localparam logic [4:0] LAST_CNT = 5'(MAGMA_ROUNDS - UNROLL);

    state_e                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [7:0][WORD_W-1:0]  rk_q, rk_d;     // rk_q[0] = K1 ... rk_q[7] = K8
    logic                    dec_q, dec_d;
    word_t                   a1_q, a1_d;
    word_t                   a0_q, a0_d;
    logic [BLOCK_W-1:0]      dout_q, dout_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;

    // Combinational chain of UNROLL rounds; stage 0 is the registered state.
    logic [UNROLL:0][WORD_W-1:0] a1_c;
    logic [UNROLL:0][WORD_W-1:0] a0_c;

    assign a1_c[0] = a1_q;
    assign a0_c[0] = a0_q;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [4:0] idx;
        assign idx = cnt_q + 5'(u);

        gost_round u_round (
            .a1_i   (a1_c[u]),
            .a0_i   (a0_c[u]),
            .rkey_i (rk_q[key_index(idx, dec_q)]),
            .a1_o   (a1_c[u+1]),
            .a0_o   (a0_c[u+1])
        );
    end

    // Next-state and next-output computation for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        rk_d    = rk_q;
        dec_d   = dec_q;
        a1_d    = a1_q;
        a0_d    = a0_q;
        dout_d  = dout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && ready_q) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    dec_d   = decrypt;
                    a1_d    = din[BLOCK_W-1:WORD_W];
                    a0_d    = din[WORD_W-1:0];
                    for (int k = 0; k < 8; k++) begin
                        rk_d[k] = key[KEY_W-1-WORD_W*k -: WORD_W];
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_STEP;
                a1_d  = a1_c[UNROLL];
                a0_d  = a0_c[UNROLL];
                if (cnt_q == LAST_CNT) begin
                    // Round 31 does not swap: undo the swap the round block always performs.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    dout_d  = {a0_c[UNROLL], a1_c[UNROLL]};
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: key and block registers are cleared too, so no stale key material survives a reset.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rk_q    <= '0;
            dec_q   <= 1'b0;
            a1_q    <= '0;
            a0_q    <= '0;
            dout_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rk_q    <= rk_d;
            dec_q   <= dec_d;
            a1_q    <= a1_d;
            a0_q    <= a0_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign dout  = dout_q;

endmodule
